// File: rtl/ks_pkg.sv
// Shared arithmetic constants for the Kogge-Stone adder family.
package ks_pkg;

  // Default operand width and the prefix-tree depth derived from it.
  localparam int unsigned KS_WIDTH  = 16;
  localparam int unsigned KS_LEVELS = $clog2(KS_WIDTH);

  // Registered adder result: carry-out above the WIDTH-bit sum.
  typedef struct packed {
    logic                carry;
    logic [KS_WIDTH-1:0] sum;
  } ks_result_t;

  // True when w is a power of two and at least 2 (legal tree width).
  function automatic bit ks_width_ok(input int unsigned w);
    return (w >= 2) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/ks_black_cell.sv
// Kogge-Stone black cell: combines group (G,P) at bit i with the group
// (G,P) that ends just below the span of i.
module ks_black_cell (
  input  logic Gi,
  input  logic Pi,
  input  logic Gj,
  input  logic Pj,
  output logic G,
  output logic P
);

  // Group generate/propagate merge.
  always_comb begin
    G = Gi | (Pi & Gj);
    P = Pi & Pj;
  end

endmodule

// File: rtl/ks_top.sv
// 16-bit Kogge-Stone parallel-prefix adder with a registered sum/carry.
// Carry-in is fixed at 0; {carry, sum} = A + B one clock after sampling.
module ks_top
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH = KS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  // Per-level group generate/propagate; index 0 is the bitwise pg stage.
  // Propagate is not needed after the final level, so that level uses
  // gray cells and the P array stops one level short.
  logic [LEVELS:0][WIDTH-1:0]   w_g;
  logic [LEVELS-1:0][WIDTH-1:0] w_p;
  logic [WIDTH-1:0]             w_p0;
  logic [WIDTH-1:0]             w_c;
  logic [WIDTH-1:0]             w_sum;
  logic                         w_carry;

  logic [WIDTH-1:0]             r_sum;
  logic                         r_carry;

  // Bitwise generate and propagate.
  always_comb begin
    w_p0   = A ^ B;
    w_g[0] = A & B;
    w_p[0] = w_p0;
  end

  // Prefix tree: level lv combines bit i with bit i - 2^lv.
  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_lvl
    localparam int D = 1 << lv;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i < D) begin : g_buf
        assign w_g[lv+1][i] = w_g[lv][i];
        if (lv < LEVELS - 1) begin : g_pbuf
          assign w_p[lv+1][i] = w_p[lv][i];
        end
      end else if (lv == LEVELS - 1) begin : g_gray
        assign w_g[lv+1][i] = w_g[lv][i] | (w_p[lv][i] & w_g[lv][i-D]);
      end else begin : g_black
        ks_black_cell u_cell (
          .Gi (w_g[lv][i]),
          .Pi (w_p[lv][i]),
          .Gj (w_g[lv][i-D]),
          .Pj (w_p[lv][i-D]),
          .G  (w_g[lv+1][i]),
          .P  (w_p[lv+1][i])
        );
      end
    end
  end

  // Carry into bit i is G[i-1:0]; carry into bit 0 is 0.
  always_comb begin
    w_c     = {w_g[LEVELS][WIDTH-2:0], 1'b0};
    w_sum   = w_p0 ^ w_c;
    w_carry = w_g[LEVELS][WIDTH-1];
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_sum   <= w_sum;
      r_carry <= w_carry;
    end
  end

  assign sum   = r_sum;
  assign carry = r_carry;

endmodule

// File: tb/tb_ks_top.sv
// Directed and random checks of the registered Kogge-Stone adder.
module tb_ks_top;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] sum;
  logic         carry;

  int unsigned  n_checks;
  int unsigned  n_errors;

  ks_top #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W:0] obs,
                          input logic [W:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got {carry,sum}=%h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive operands away from the edge, then sample just after the next edge.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  // Directed vectors with hand-computed 17-bit results.
  localparam int NV = 13;
  logic [W-1:0] va [NV] = '{16'd0, 16'd10, 16'd105, 16'd10, 16'h1111,
                            16'h1111, 16'd65535, 16'd10000, 16'd20001,
                            16'd7890, 16'h8000, 16'hFFFF, 16'hAAAA};
  logic [W-1:0] vb [NV] = '{16'd1, 16'd21, 16'd211, 16'd101, 16'h0001,
                            16'h1000, 16'd1, 16'd1, 16'd345,
                            16'd31435, 16'h8000, 16'hFFFF, 16'h5555};
  logic [W:0]   ve [NV] = '{17'd1, 17'd31, 17'd316, 17'd111, 17'h01112,
                            17'h02111, 17'h10000, 17'd10001, 17'd20346,
                            17'h0999D, 17'h10000, 17'h1FFFE, 17'h0FFFF};

  initial begin
    logic [W-1:0] ra, rb;
    logic [W:0]   rexp;
    n_checks = 0;
    n_errors = 0;

    // Reset asserted before any clock edge: outputs clear without a clock.
    rst = 1'b1;
    A   = 16'hFFFF;
    B   = 16'h0001;
    #2;
    check_eq("reset_noclk", {carry, sum}, 17'h0);
    @(posedge clk);
    #1;
    check_eq("reset_held", {carry, sum}, 17'h0);

    // Release reset; first edge with rst low registers FFFF + 1.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("first_after_reset", {carry, sum}, 17'h10000);

    // Directed table, one result per cycle.
    for (int i = 0; i < NV; i++) begin
      apply(va[i], vb[i]);
      check_eq($sformatf("vec%0d", i), {carry, sum}, ve[i]);
    end

    // Inputs held: result stays put on subsequent edges.
    @(posedge clk);
    #1;
    check_eq("hold", {carry, sum}, 17'h0FFFF);

    // Asynchronous reset mid-operation, between clock edges.
    apply(16'hFFFF, 16'hFFFF);
    check_eq("pre_async_rst", {carry, sum}, 17'h1FFFE);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst", {carry, sum}, 17'h0);
    @(negedge clk);
    rst = 1'b0;
    check_eq("async_rst_release", {carry, sum}, 17'h0);

    // Back-to-back random operands, new pair every cycle.
    for (int n = 0; n < 10000; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb};
      apply(ra, rb);
      check_eq("random", {carry, sum}, rexp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ks_top.md
# ks_top

16-bit Kogge-Stone parallel-prefix adder with a registered result. It adds two unsigned operands and produces a sum and a carry-out one clock after the operands are presented. It sits as a leaf arithmetic block in the datapath and serves as the reference fast adder for the team's arithmetic units.

## Interface
- WIDTH, 16, operand/sum width; must be a power of two ≥ 2 (prefix depth = log2(WIDTH)).
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- sum  output  WIDTH  registered (A + B) mod 2^WIDTH.
- carry  output  1  registered carry-out, bit WIDTH of A + B.

## Operation
- No carry-in; carry-in is fixed at 0.
- Pre-processing per bit i: g_i = A_i & B_i, p_i = A_i ^ B_i.
- Prefix tree: log2(WIDTH) levels, level k span d = 2^k; for every i ≥ d: G = G_i | (P_i & G_{i-d}), P = P_i & P_{i-d}; for i < d pass-through (buffer).
- Group generate G[i:0] after final level is the carry into bit i+1; c_0 = 0.
- sum_i = p_i ^ c_i; carry = G[WIDTH-1:0].
- Result is bit-exact with unsigned A + B: {carry, sum} = A + B (WIDTH+1 bits); no saturation, overflow only signalled by carry.
- Tree is purely combinational between input ports and the output register; no input registering.

## Timing
- Latency: 1 cycle; A/B sampled at rising edge N appear on sum/carry after edge N.
- Throughput: one new addition per cycle, no handshake, no stall.
- Reset: while rst = 1, sum = 0 and carry = 0 immediately (asynchronous), held until rst deasserts; first valid result is registered on the first rising edge with rst = 0.
- Reset mid-operation: in-flight result is discarded; no other state exists.
- Inputs held constant: outputs stable from one cycle after the last change.
- Critical path: WIDTH-bit pg generation + log2(WIDTH) black-cell levels + sum XOR; must close at the datapath clock with no multicycle constraint.

## Structure
- Shared arithmetic package: default WIDTH constant (16) and derived LEVELS = $clog2(WIDTH) localparam.
- One sub-module: ks_black_cell (inputs Gi, Pi, Gj, Pj; outputs G, P), instantiated via generate loops per level/bit; gray cells (G only) are optional and functionally equivalent.
- Top level contains pg stage, generated prefix tree, sum XOR and the output register.

## Test plan
- Reset: assert rst with A = 16'hFFFF, B = 1 -> sum = 0, carry = 0 during reset, without waiting for a clock edge.
- Basic: A = 0, B = 1 -> sum = 1, carry = 0; A = 10, B = 21 -> sum = 31; A = 105, B = 211 -> sum = 316; A = 10, B = 101 -> sum = 111; all carry = 0, each result visible one cycle after the inputs are applied.
- Sparse bits: A = 16'h1111, B = 16'h0001 -> 16'h1112; A = 16'h1111, B = 16'h1000 -> 16'h2111; carry = 0.
- Full carry ripple: A = 65535, B = 1 -> sum = 0, carry = 1; A = 10000, B = 1 -> sum = 10001, carry = 0.
- Mixed: A = 20001, B = 345 -> 20346; A = 7890, B = 31435 -> 39325 (16'h999D), carry = 0.
- Back-to-back plus random: new operands every cycle and ≥10k random pairs -> each {carry, sum} equals the 17-bit A + B of the previous cycle.
